// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator (PC register, next-PC select, optional jr return-address stack).
// Latency: every PC / RAS change is registered; pc and ras_pred_* reflect inputs one edge later.
// Backpressure: stall holds pc and blocks RAS updates; flush_valid overrides stall. Option macro: PC_GEN_RAS_EN.
module pc_gen #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(32'h0000_3000),
  parameter int               RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             stall,
  input  logic                             flush_valid,
  input  logic [WIDTH-1:0]                 flush_target,
  input  logic [WIDTH-1:0]                 id_pc,
  input  logic                             br_taken,
  input  logic [WIDTH-1:0]                 br_target,
  input  logic                             jr_valid,
  input  logic [WIDTH-1:0]                 jr_target,
  input  logic                             j_valid,
  input  logic                             j_link,
  input  logic [25:0]                      j_index,
  output logic [WIDTH-1:0]                 pc,
  output logic                             ras_pred_valid,
  output logic [WIDTH-1:0]                 ras_pred_target,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count
);

  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] j_tgt;
  logic [WIDTH-1:0] jr_sel;
  logic             accept;

  // The ID instruction only takes effect when nothing upstream holds or overrides it.
  assign accept = !flush_valid && !stall;

  // Jump target keeps the top PC bits of the jump itself and replaces the low 28.
  always_comb begin
    j_tgt       = id_pc;
    j_tgt[27:0] = {j_index, 2'b00};
  end

`ifdef PC_GEN_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pv_q, pv_d;
  logic [WIDTH-1:0] pt_q, pt_d;
  logic             ras_hit;

  // ptr points at the next free slot; the top of stack is one below, wrapping circularly.
  assign top_idx = ptr_q - PW'(1);
  assign ras_hit = (cnt_q != '0);
  assign jr_sel  = ras_hit ? ras_q[top_idx] : jr_target;

  // Push on accepted jal, pop on accepted jr; a taken branch or jr suppresses the jal push.
  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    pv_d  = 1'b0;
    pt_d  = pt_q;
    if (accept && !br_taken) begin
      if (jr_valid) begin
        if (ras_hit) begin
          ptr_d = top_idx;
          cnt_d = cnt_q - CW'(1);
          pv_d  = 1'b1;
          pt_d  = ras_q[top_idx];
        end
      end else if (j_valid && j_link) begin
        // When full the write lands on the oldest entry and the count saturates.
        ras_d[ptr_q] = id_pc + WIDTH'(4);
        ptr_d        = ptr_q + PW'(1);
        if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // RAS storage, pointer, count and prediction registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      pv_q  <= 1'b0;
      pt_q  <= '0;
    end else begin
      ras_q <= ras_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      pv_q  <= pv_d;
      pt_q  <= pt_d;
    end
  end

  assign ras_pred_valid  = pv_q;
  assign ras_pred_target = pt_q;
  assign ras_count       = cnt_q;
`else
  logic unused_ok;

  // Without the RAS, jr always waits for the forwarded rs value.
  assign jr_sel          = jr_target;
  assign ras_pred_valid  = 1'b0;
  assign ras_pred_target = '0;
  assign ras_count       = '0;
  assign unused_ok       = j_link;
`endif

  // Next-PC priority: flush, stall, branch, jr, j, sequential.
  always_comb begin
    pc_d = pc_q + WIDTH'(4);
    if (flush_valid)   pc_d = flush_target;
    else if (stall)    pc_d = pc_q;
    else if (br_taken) pc_d = br_target;
    else if (jr_valid) pc_d = jr_sel;
    else if (j_valid)  pc_d = j_tgt;
  end

  // PC register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule
